// File: rtl/uart_bcd_frame_tx_pkg.sv
// Shared definitions for the BCD frame serialiser: ASCII constants,
// FSM state encoding and the saturation limit of the drop counter.
package uart_bcd_frame_tx_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_QM    = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIGIT = 3'd1,
    ST_SEP   = 3'd2,
    ST_CR    = 3'd3,
    ST_LF    = 3'd4
  } state_e;

endpackage

// File: rtl/uart_bcd_frame_tx_if.sv
// Byte stream towards the UART transmitter (valid/ready).
//   tx_data  : ASCII byte, master -> slave
//   tx_valid : tx_data is valid, master -> slave
//   tx_ready : slave accepts the byte this cycle, slave -> master
interface uart_bcd_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bcd_frame_tx_digit.sv
// Combinational BCD nibble to ASCII converter.
//   nib     : BCD nibble in
//   ascii   : '0'..'9' for 0..9, '?' for A..F
//   is_zero : nibble is exactly zero (A..F count as non-zero)
module bcd_ascii_digit
  import uart_bcd_frame_tx_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii,
  output logic       is_zero
);

  always_comb begin
    is_zero = (nib == 4'd0);
    if (nib <= 4'd9) ascii = ASCII_0 + {4'h0, nib};
    else             ascii = ASCII_QM;
  end

endmodule

// File: rtl/uart_bcd_frame_tx.sv
// Multi-channel BCD-to-ASCII frame serialiser. A trigger snapshots all
// channels and emits one text line, e.g. "0123,9000\r\n", over a
// valid/ready byte interface.
//   clk, reset : clock, synchronous active-high reset
//   data       : ch c digit d (d=0 is LSD) at [(c*NUM_DIGITS+d)*4 +: 4]
//   trigger    : request one frame (ignored and counted while busy)
//   tx         : byte stream master (tx_data/tx_valid/tx_ready)
//   busy       : frame in progress
//   dropped    : saturating count of triggers ignored while busy
module uart_bcd_frame_tx
  import uart_bcd_frame_tx_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter int         NUM_DIGITS  = 8,
  parameter int         LZ_SUPPRESS = 0,
  parameter logic [7:0] SEP_CHAR    = 8'h2C,
  parameter int         CRLF        = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH*NUM_DIGITS*4-1:0]   data,
  input  logic                             trigger,
  uart_bcd_frame_tx_if.master              tx,
  output logic                             busy,
  output logic [7:0]                       dropped
);

  localparam int CW = $clog2(NUM_CH) + 1;
  localparam int DW = $clog2(NUM_DIGITS) + 1;
  localparam int SW = NUM_CH * NUM_DIGITS * 4;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic [DW-1:0] TOP_DIG = DW'(NUM_DIGITS - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] snap_q, snap_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [DW-1:0] dig_q, dig_d;
  logic          seen_q, seen_d;   // a digit of this channel has been emitted
  logic [7:0]    dropped_q, dropped_d;

  logic [3:0]    cur_nib;
  logic [7:0]    cur_ascii;
  logic          cur_zero;
  logic          skip;

  // Digit select: mux over the snapshot indexed by (channel, digit).
  always_comb begin
    cur_nib = 4'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (ch_q == c[CW-1:0] && dig_q == d[DW-1:0])
          cur_nib = snap_q[(c*NUM_DIGITS+d)*4 +: 4];
      end
    end
  end

  bcd_ascii_digit u_digit (
    .nib     (cur_nib),
    .ascii   (cur_ascii),
    .is_zero (cur_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      ch_q      <= '0;
      dig_q     <= '0;
      seen_q    <= 1'b0;
      dropped_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      ch_q      <= ch_d;
      dig_q     <= dig_d;
      seen_q    <= seen_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ch_d        = ch_q;
    dig_d       = dig_q;
    seen_d      = seen_q;
    skip        = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          snap_d  = data;
          ch_d    = '0;
          dig_d   = TOP_DIG;
          seen_d  = 1'b0;
          state_d = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        // Leading zero skipped without a handshake; digit 0 always goes out.
        skip        = (LZ_SUPPRESS != 0) && cur_zero && !seen_q && (dig_q != '0);
        tx.tx_valid = !skip;
        tx.tx_data  = cur_ascii;
        if (skip || tx.tx_ready) begin
          seen_d = seen_q || !cur_zero;
          if (dig_q != '0)          dig_d   = dig_q - DW'(1);
          else if (ch_q != LAST_CH) state_d = ST_SEP;
          else                      state_d = (CRLF != 0) ? ST_CR : ST_LF;
        end
      end
      ST_SEP: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = SEP_CHAR;
        if (tx.tx_ready) begin
          ch_d    = ch_q + CW'(1);
          dig_d   = TOP_DIG;
          seen_d  = 1'b0;
          state_d = ST_DIGIT;
        end
      end
      ST_CR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ASCII_CR;
        if (tx.tx_ready) state_d = ST_LF;
      end
      ST_LF: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ASCII_LF;
        if (tx.tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A trigger landing on the final LF acceptance still sees a busy FSM.
  always_comb begin
    dropped_d = dropped_q;
    if (trigger && state_q != ST_IDLE && dropped_q != DROP_MAX)
      dropped_d = dropped_q + 8'd1;
  end

  assign busy    = (state_q != ST_IDLE);
  assign dropped = dropped_q;

endmodule

// File: tb/tb_uart_bcd_frame_tx.sv
// Bench for uart_bcd_frame_tx: three instances (LZ=0/CRLF=1, LZ=1/CRLF=1,
// LZ=0/CRLF=0) with NUM_CH=2, NUM_DIGITS=4, checked against a text model.
module tb_uart_bcd_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [2:0]  trig;
  logic [2:0]  rdy;
  logic [2:0]  valid_v;
  logic [2:0]  busy_v;
  logic [7:0]  tx_data_v [3];
  logic [7:0]  dropped_v [3];

  int          total = 0;
  int          bad = 0;
  int          exp_drop [3];
  int          last_cycles;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  uart_bcd_frame_tx_if bus0 ();
  uart_bcd_frame_tx_if bus1 ();
  uart_bcd_frame_tx_if bus2 ();

  uart_bcd_frame_tx #(.NUM_CH(2), .NUM_DIGITS(4), .LZ_SUPPRESS(0), .SEP_CHAR(8'h2C), .CRLF(1)) dut0 (
    .clk(clk), .reset(reset), .data(data_in), .trigger(trig[0]), .tx(bus0),
    .busy(busy_v[0]), .dropped(dropped_v[0]));
  uart_bcd_frame_tx #(.NUM_CH(2), .NUM_DIGITS(4), .LZ_SUPPRESS(1), .SEP_CHAR(8'h2C), .CRLF(1)) dut1 (
    .clk(clk), .reset(reset), .data(data_in), .trigger(trig[1]), .tx(bus1),
    .busy(busy_v[1]), .dropped(dropped_v[1]));
  uart_bcd_frame_tx #(.NUM_CH(2), .NUM_DIGITS(4), .LZ_SUPPRESS(0), .SEP_CHAR(8'h2C), .CRLF(0)) dut2 (
    .clk(clk), .reset(reset), .data(data_in), .trigger(trig[2]), .tx(bus2),
    .busy(busy_v[2]), .dropped(dropped_v[2]));

  assign valid_v[0]   = bus0.tx_valid;
  assign valid_v[1]   = bus1.tx_valid;
  assign valid_v[2]   = bus2.tx_valid;
  assign tx_data_v[0] = bus0.tx_data;
  assign tx_data_v[1] = bus1.tx_data;
  assign tx_data_v[2] = bus2.tx_data;
  assign bus0.tx_ready = rdy[0];
  assign bus1.tx_ready = rdy[1];
  assign bus2.tx_ready = rdy[2];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line built straight from the text rules.
  function automatic void model(input logic [31:0] d, input bit lz, input bit crlf);
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      bit started;
      started = 1'b0;
      for (int g = 3; g >= 0; g--) begin
        logic [3:0] n;
        n = d[(c*4+g)*4 +: 4];
        if (lz && !started && n == 4'd0 && g != 0) continue;
        started = 1'b1;
        exp_q.push_back(n <= 4'd9 ? 8'h30 + {4'h0, n} : 8'h3F);
      end
      if (c == 0) exp_q.push_back(8'h2C);
    end
    if (crlf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic start_frame(input int k);
    @(negedge clk);
    trig[k] = 1'b1;
    @(negedge clk);
    trig[k] = 1'b0;
    #1;
    chk("busy_after_trigger", {31'd0, busy_v[k]}, 32'd1);
  endtask

  // Collect bytes until LF (or max_bytes); checks hold-stability on stalls.
  task automatic collect(input int k, input int duty, input int max_bytes, input bit inject);
    bit         held;
    bit         done;
    logic [7:0] hd;
    int         cyc;
    held = 1'b0;
    done = 1'b0;
    hd   = 8'h00;
    cyc  = 0;
    got_q.delete();
    while (!done && cyc < 400) begin
      rdy[k] = ($urandom_range(0, 99) < duty);
      if (inject) begin
        trig[k] = (cyc == 2 || cyc == 4 || cyc == 6);
        if (cyc == 1) data_in = $urandom;
        if (trig[k] && exp_drop[k] < 255) exp_drop[k]++;
      end
      #1;
      if (held) begin
        chk("hold_valid", {31'd0, valid_v[k]}, 32'd1);
        chk("hold_data", {24'd0, tx_data_v[k]}, {24'd0, hd});
      end
      if (valid_v[k] && rdy[k]) begin
        got_q.push_back(tx_data_v[k]);
        held = 1'b0;
        if (tx_data_v[k] == 8'h0A || got_q.size() == max_bytes) done = 1'b1;
      end else begin
        held = valid_v[k];
        hd   = tx_data_v[k];
      end
      @(negedge clk);
      cyc++;
    end
    trig[k] = 1'b0;
    last_cycles = cyc;
    chk("frame_complete", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input int k, input string tag);
    int n;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    #1;
    chk({tag, "_busy_end"}, {31'd0, busy_v[k]}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    trig    = 3'b000;
    rdy     = 3'b111;
    data_in = 32'h0;
    for (int k = 0; k < 3; k++) exp_drop[k] = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", {31'd0, valid_v[k]}, 32'd0);
      chk("rst_data", {24'd0, tx_data_v[k]}, 32'd0);
      chk("rst_busy", {31'd0, busy_v[k]}, 32'd0);
      chk("rst_dropped", {24'd0, dropped_v[k]}, 32'd0);
    end
    reset = 1'b0;

    // plain frame, full-rate sink: first byte right after trigger, no bubbles
    data_in = 32'h9000_0123;
    model(data_in, 1'b0, 1'b1);
    start_frame(0);
    chk("first_valid", {31'd0, valid_v[0]}, 32'd1);
    chk("first_byte", {24'd0, tx_data_v[0]}, 32'h30);
    collect(0, 100, 0, 1'b0);
    check_frame(0, "plain");
    chk("plain_cycles", last_cycles, 32'd11);

    // leading-zero suppression
    model(data_in, 1'b1, 1'b1);
    start_frame(1);
    collect(1, 100, 0, 1'b0);
    check_frame(1, "lz");
    data_in = 32'h0;
    model(data_in, 1'b1, 1'b1);
    start_frame(1);
    collect(1, 100, 0, 1'b0);
    check_frame(1, "lz_zero");

    // backpressure
    data_in = 32'h9000_0123;
    model(data_in, 1'b0, 1'b1);
    rdy[0] = 1'b0;
    start_frame(0);
    collect(0, 30, 0, 1'b0);
    check_frame(0, "bp");

    // triggers while busy, data changes after snapshot
    model(data_in, 1'b0, 1'b1);
    start_frame(0);
    collect(0, 100, 0, 1'b1);
    check_frame(0, "drop3");
    chk("dropped3", {24'd0, dropped_v[0]}, exp_drop[0]);
    chk("dropped3_abs", {24'd0, dropped_v[0]}, 32'd3);

    // saturation: stall the sink and hammer trigger
    model(data_in, 1'b0, 1'b1);
    rdy[0] = 1'b0;
    start_frame(0);
    trig[0] = 1'b1;
    repeat (300) @(negedge clk);
    trig[0] = 1'b0;
    exp_drop[0] = (exp_drop[0] + 300 > 255) ? 255 : exp_drop[0] + 300;
    #1;
    chk("dropped_sat", {24'd0, dropped_v[0]}, exp_drop[0]);
    collect(0, 100, 0, 1'b0);
    check_frame(0, "after_sat");

    // non-BCD digit, and LF-only line ending
    data_in = 32'h9000_01A3;
    model(data_in, 1'b0, 1'b1);
    start_frame(0);
    collect(0, 100, 0, 1'b0);
    check_frame(0, "qm");
    model(data_in, 1'b0, 1'b0);
    start_frame(2);
    collect(2, 100, 0, 1'b0);
    check_frame(2, "lf_only");

    // random data and sink duty on every configuration
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 3; k++) begin
        data_in = $urandom;
        model(data_in, k == 1, k != 2);
        start_frame(k);
        collect(k, $urandom_range(20, 100), 0, 1'b0);
        check_frame(k, $sformatf("rnd%0d_%0d", it, k));
      end
    end
    for (int k = 0; k < 3; k++)
      chk("dropped_final", {24'd0, dropped_v[k]}, exp_drop[k]);

    // reset mid-frame after the fifth byte
    data_in = 32'h9000_0123;
    model(data_in, 1'b0, 1'b1);
    start_frame(0);
    collect(0, 100, 5, 1'b0);
    chk("mid_bytes", got_q.size(), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) exp_drop[k] = 0;
    #1;
    chk("mid_rst_valid", {31'd0, valid_v[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("mid_rst_dropped", {24'd0, dropped_v[0]}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_quiet", {31'd0, valid_v[0]}, 32'd0);
    start_frame(0);
    collect(0, 100, 0, 1'b0);
    check_frame(0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
